// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Define BIN2BCD_SATURATE_EN to flag values >= 10**DIGITS and saturate bcd to all nines.
module bin2bcd_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    ready,
    output logic                    done,
    output logic [DIGITS-1:0][3:0]  bcd,
    output logic                    ovf
);

    // ceil(BIN_W*log10(2)) with a fixed-point log10(2); enough digits for 2**BIN_W-1
    localparam int WD_RAW = (BIN_W * 30103 + 99999) / 100000;
    localparam int WD     = (WD_RAW < 1) ? 1 : WD_RAW;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [BIN_W-1:0]       bin_reg;
    logic [WD-1:0][3:0]     work_reg;
    logic [WD-1:0][3:0]     work_adj;
    logic [WD*4-1:0]        work_adj_flat;
    logic [WD*4-1:0]        work_next;
    logic                   ready_reg;
    logic                   done_reg;
    logic [DIGITS-1:0][3:0] bcd_reg;
    logic [DIGITS-1:0][3:0] bcd_next;
    logic [DIGITS-1:0][3:0] trunc;
    logic                   ovf_reg;
    logic                   ovf_next;

    genvar gi;
    generate
        for (gi = 0; gi < WD; gi++) begin : g_adj
            assign work_adj[gi] = (work_reg[gi] >= 4'd5) ? (work_reg[gi] + 4'd3) : work_reg[gi];
        end

        for (gi = 0; gi < DIGITS; gi++) begin : g_trunc
            if (gi < WD) begin : g_use
                assign trunc[gi] = work_reg[gi];
            end else begin : g_pad
                assign trunc[gi] = 4'd0;
            end
        end
    endgenerate

    assign work_adj_flat = work_adj;
    assign work_next     = {work_adj_flat[WD*4-2:0], bin_reg[BIN_W-1]};

`ifdef BIN2BCD_SATURATE_EN
    // Any nonzero digit above the output width means the value cannot be shown
    logic [WD-1:0] hi_nz;
    generate
        for (gi = 0; gi < WD; gi++) begin : g_hi
            if (gi >= DIGITS) begin : g_chk
                assign hi_nz[gi] = |work_reg[gi];
            end else begin : g_low
                assign hi_nz[gi] = 1'b0;
            end
        end
    endgenerate
    assign ovf_next = |hi_nz;
    assign bcd_next = ovf_next ? {DIGITS{4'h9}} : trunc;
`else
    assign ovf_next = 1'b0;
    assign bcd_next = trunc;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bin_reg   <= '0;
            work_reg  <= '0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        bin_reg   <= bin;
                        cnt_reg   <= CNT_W'(BIN_W);
                        work_reg  <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_reg <= work_next;
                    bin_reg  <= bin_reg << 1;
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // Results land at the end of DONE so done rises as ready returns
                    bcd_reg   <= bcd_next;
                    ovf_reg   <= ovf_next;
                    done_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign done  = done_reg;
    assign bcd   = bcd_reg;
    assign ovf   = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes hand-computed results,
// a negedge monitor pops them on each done pulse and checks value, latency and hold.
module tb_bin2bcd_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

`ifdef BIN2BCD_SATURATE_EN
    localparam logic [15:0] EXP_16383_BCD = 16'h9999;
    localparam logic        EXP_16383_OVF = 1'b1;
    localparam logic [15:0] EXP_10000_BCD = 16'h9999;
    localparam logic        EXP_10000_OVF = 1'b1;
`else
    localparam logic [15:0] EXP_16383_BCD = 16'h6383;
    localparam logic        EXP_16383_OVF = 1'b0;
    localparam logic [15:0] EXP_10000_BCD = 16'h0000;
    localparam logic        EXP_10000_OVF = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   resetN = 1'b0;
    logic                   start = 1'b0;
    logic [BIN_W-1:0]       bin = '0;
    logic                   ready;
    logic                   done;
    logic [DIGITS-1:0][3:0] bcd;
    logic                   ovf;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_done = 0;
    int          last_done_cyc = 0;
    int          prev_done_cyc = 0;
    logic [15:0] hold_bcd = '0;
    logic        hold_ovf = 1'b0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .resetN(resetN),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Acceptance observer: records the edge index of every accepted start
    always @(posedge clk) begin
        cyc++;
        if (!resetN) begin
            acc_q.delete();
            hold_bcd = '0;
            hold_ovf = 1'b0;
        end else if (start && ready) begin
            acc_q.push_back(cyc);
            n_acc++;
        end
    end

    // Monitor: compares each done pulse against the scoreboard, else checks hold
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                exp_t e;
                int   a;
                n_done++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                    check("bcd", 32'(bcd), 32'(e.bcd));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("latency", 32'(cyc - a), 32'd15);
                    hold_bcd = e.bcd;
                    hold_ovf = e.ovf;
                    $display("xact %0d: bcd=%h ovf=%b latency=%0d", n_done, bcd, ovf, cyc - a);
                end
            end else begin
                check("bcd_hold", 32'(bcd), 32'(hold_bcd));
                check("ovf_hold", 32'(ovf), 32'(hold_ovf));
            end
        end
    end

    task automatic push_exp(input logic [15:0] b, input logic o);
        exp_t e;
        e.bcd = b;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic convert(input logic [BIN_W-1:0] v, input logic [15:0] eb, input logic eo);
        bin   = v;
        start = 1'b1;
        push_exp(eb, eo);
        @(negedge clk);
        start = 1'b0;
        bin   = ~v;
        check("ready_low", 32'(ready), 32'd0);
        wait_idle();
    endtask

    initial begin
        int n0;
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done",  32'(done),  32'd0);
        check("rst_bcd",   32'(bcd),   32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        resetN = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        convert(14'd1234, 16'h1234, 1'b0);

        // Back-to-back with start held high
        n0    = n_acc;
        bin   = 14'd0;
        start = 1'b1;
        push_exp(16'h0000, 1'b0);
        push_exp(16'h9999, 1'b0);
        @(negedge clk);
        bin = 14'd9999;
        for (int i = 0; i < 40 && n_acc < n0 + 2; i++) @(negedge clk);
        check("b2b_accepts", 32'(n_acc - n0), 32'd2);
        start = 1'b0;
        wait_idle();
        check("b2b_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd16);

        convert(14'd16383, EXP_16383_BCD, EXP_16383_OVF);
        convert(14'd9,     16'h0009, 1'b0);
        convert(14'd8191,  16'h8191, 1'b0);
        convert(14'd10000, EXP_10000_BCD, EXP_10000_OVF);

        // Start during a conversion is dropped
        n0    = n_done;
        bin   = 14'd500;
        start = 1'b1;
        push_exp(16'h0500, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin   = 14'd42;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("single_done", 32'(n_done - n0), 32'd1);

        // Reset mid-conversion aborts it
        bin   = 14'd777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        resetN = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        resetN = 1'b1;
        start  = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_bcd",   32'(bcd),   32'd0);
        check("abort_ovf",   32'(ovf),   32'd0);
        check("abort_done",  32'(done),  32'd0);
        n0 = n_done;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(n_done - n0), 32'd0);
        convert(14'd777, 16'h0777, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
